// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter: shares one 16:1 register-file read mux among NUM_REQ requesters
// Ports:
//   clk        in  system clock, rising edge
//   reset_n    in  asynchronous active-low reset
//   req        in  per-requester read request, held high until ack
//   req_addr   in  4-bit register index per requester, [4i+3:4i] = requester i
//   ack        out one-hot single-cycle pulse marking rd_data valid for that requester
//   rd_data    out registered read data, valid in the ack cycle
//   reg_select out select to the 16:1 register mux
//   mux_output in  combinational data from the 16:1 register mux
//   busy       out high in SELECT and RESP
// Option: define REGARB_FIXED_PRIO_EN to give requester 0 absolute priority,
// with round-robin among the remaining requesters.
module regfile_read_arbiter #(
   parameter int NUM_REQ = 3
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [4*NUM_REQ-1:0]   req_addr,
   output logic [NUM_REQ-1:0]     ack,
   output logic [15:0]            rd_data,
   output logic [3:0]             reg_select,
   input  logic [15:0]            mux_output,
   output logic                   busy
);
   localparam int IW = 3;
   typedef enum logic [1:0] {IDLE, SELECT, RESP} state_t;
   state_t             r_state, w_next;
   logic [IW-1:0]      r_g, r_ptr, w_win, w_ptr_nx;
   logic [15:0]        r_rd_data;
   logic [NUM_REQ-1:0] w_gmask, w_elig;
   logic               w_found, w_grant, w_live;
   logic [3:0]         w_addr_g;
   int                 idx;
   // Arbitration; in RESP the requester just served sits out one round.
   always_comb begin
      w_gmask = NUM_REQ'(1) << r_g;
      w_elig  = (r_state == RESP) ? (req & ~w_gmask) : req;
      w_found = 1'b0;
      w_win   = '0;
      idx     = 0;
`ifdef REGARB_FIXED_PRIO_EN
      w_found = w_elig[0];
`endif
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(r_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!w_found && |(w_elig & (NUM_REQ'(1) << idx))) begin
            w_found = 1'b1;
            w_win   = IW'(idx);
         end
      end
`ifdef REGARB_FIXED_PRIO_EN
      // Requester 0 never moves the pointer; it wraps back to 1, not 0.
      w_ptr_nx = (w_win == '0) ? r_ptr : (w_win == IW'(NUM_REQ-1)) ? IW'(1) : w_win + IW'(1);
`else
      w_ptr_nx = (w_win == IW'(NUM_REQ-1)) ? '0 : w_win + IW'(1);
`endif
   end
   assign w_addr_g = req_addr[4*r_g +: 4];
   assign w_live   = |(req & w_gmask);
   always_comb begin
      w_next  = r_state;
      w_grant = 1'b0;
      case (r_state)
         IDLE: begin
            w_next  = w_found ? SELECT : IDLE;
            w_grant = w_found;
         end
         SELECT: w_next = w_live ? RESP : IDLE;
         RESP: begin
            w_next  = w_found ? SELECT : IDLE;
            w_grant = w_found;
         end
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_g       <= '0;
         r_ptr     <= '0;
         r_rd_data <= '0;
      end else begin
         r_state <= w_next;
         if (w_grant) begin
            r_g   <= w_win;
            r_ptr <= w_ptr_nx;
         end
         if (r_state == SELECT && w_live) r_rd_data <= mux_output;
      end
   end
   // Outputs depend only on registered state, so req never reaches ack combinationally.
   assign ack        = (r_state == RESP) ? w_gmask : '0;
   assign rd_data    = r_rd_data;
   assign reg_select = (r_state == IDLE) ? 4'd0 : w_addr_g;
   assign busy       = (r_state != IDLE);
endmodule

// File: tb/tb_regfile_read_arbiter.sv
// tb_regfile_read_arbiter: scoreboard bench for regfile_read_arbiter
module tb_regfile_read_arbiter;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  req;
   logic [11:0] req_addr;
   logic [2:0]  ack;
   logic [15:0] rd_data;
   logic [3:0]  reg_select;
   logic [15:0] mux_output;
   logic        busy;
   logic [15:0] regs [16];
   logic [18:0] q [$];
   int checks = 0;
   int errors = 0;
   localparam logic [15:0] VA = 16'h1234, VB = 16'h5678, VC = 16'h9ABC, VF = 16'hBEEF;

   regfile_read_arbiter #(.NUM_REQ(3)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr), .ack(ack),
      .rd_data(rd_data), .reg_select(reg_select), .mux_output(mux_output), .busy(busy)
   );

   always #5 clk = ~clk;
   assign mux_output = regs[reg_select];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (ack != 3'b000) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack actual=%0h required=none", ack);
         end else begin
            logic [18:0] e;
            e = q.pop_front();
            chk("sb_ack", ack, e[18:16]);
            chk("sb_data", rd_data, e[15:0]);
         end
      end
   end

   initial begin
      for (int i = 0; i < 16; i++) regs[i] = 16'h0F00 + 16'(i);
      regs[1] = VA; regs[2] = VB; regs[3] = VC; regs[5] = VF;
      reset_n = 1'b1; req = 3'b000; req_addr = {4'd3, 4'd2, 4'd1};
      #1 reset_n = 1'b0; req = 3'b111;
      repeat (3) begin
         @(negedge clk);
         chk("rst_hold", {ack, rd_data, reg_select, busy}, 0);
      end
`ifdef REGARB_FIXED_PRIO_EN
      q.push_back({3'b001, VA}); q.push_back({3'b010, VB});
      q.push_back({3'b001, VA}); q.push_back({3'b100, VC});
`else
      q.push_back({3'b001, VA}); q.push_back({3'b010, VB});
      q.push_back({3'b100, VC}); q.push_back({3'b001, VA});
`endif
      @(posedge clk); #1 reset_n = 1'b1;
      repeat (8) @(posedge clk);
      #1 req = 3'b000;
      @(posedge clk); #1 req_addr[7:4] = 4'd5; req = 3'b010;
      q.push_back({3'b010, VF});
      @(posedge clk);
      @(negedge clk);
      chk("single_sel", reg_select, 4'd5);
      chk("single_busy", busy, 1);
      @(posedge clk); #1 req = 3'b000;
      @(posedge clk); #1 req = 3'b100;
      @(posedge clk); #1 req = 3'b000;
      @(negedge clk);
      chk("abort_sel", reg_select, 4'd3);
      @(posedge clk); #1;
      chk("abort_idle", {ack, busy}, 0);
      req = 3'b101;
      q.push_back({3'b001, VA});
      @(posedge clk);
      @(posedge clk); #1 req = 3'b100;
      q.push_back({3'b100, VC});
      @(posedge clk);
      @(posedge clk); #1 req = 3'b000;
      @(posedge clk); #1 req = 3'b010;
      @(posedge clk);
      @(posedge clk); #1;
      chk("pre_rst_ack", ack, 3'b010);
      chk("pre_rst_data", rd_data, VF);
      reset_n = 1'b0;
      #1;
      chk("rst_ack_fall", ack, 0);
      chk("rst_outs", {rd_data, reg_select, busy}, 0);
      req = 3'b000; req_addr[7:4] = 4'd2;
      @(posedge clk); #1 reset_n = 1'b1; req = 3'b111;
      q.push_back({3'b001, VA});
      @(negedge clk);
      chk("post_rst_idle", busy, 0);
      @(posedge clk);
      @(posedge clk); #1 req = 3'b000;
      repeat (3) @(posedge clk);
      #1;
      chk("sb_drain", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
